// File: rtl/data_unit_pkg.sv
// Shared globals for the data unit: ALU codes, opcodes and instruction-word layout.
package data_unit_pkg;

   localparam int DW   = 8;
   localparam int IW   = 16;
   localparam int NREG = 8;
   localparam int RW   = 3;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_TRB = 2'd2;
   localparam logic [1:0] ALU_TRA = 2'd3;

   localparam logic [4:0] LDI = 5'd1;
   localparam logic [4:0] ADD = 5'd2;
   localparam logic [4:0] SUB = 5'd3;
   localparam logic [4:0] MOV = 5'd4;

   // imm overlaps ra/rb/pad, so it is recovered by concatenation
   typedef struct packed {
      logic [4:0]    opcode;
      logic [RW-1:0] rd;
      logic [RW-1:0] ra;
      logic [RW-1:0] rb;
      logic [1:0]    pad;
   } ir_t;

   function automatic logic [DW-1:0] ir_imm(input ir_t ir);
      return {ir.ra, ir.rb, ir.pad};
   endfunction

endpackage

// File: rtl/data_unit_alu.sv
// Combinational 8-bit ALU: ADD, SUB, pass-B, pass-A; cout is carry (ADD) or borrow (SUB).
module alu
   import data_unit_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [1:0]    operation,
   output logic [DW-1:0] result,
   output logic          cout
);

   logic [DW:0] sum;
   logic [DW:0] dif;

   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      cout   = 1'b0;
      case (operation)
         ALU_ADD: begin result = sum[DW-1:0]; cout = sum[DW]; end
         ALU_SUB: begin result = dif[DW-1:0]; cout = dif[DW]; end
         ALU_TRB: result = b;
         ALU_TRA: result = a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/data_unit.sv
// Datapath: PC, IR, 8x8 register file and ALU. Status flags exist only when
// YASAC_FLAGS_EN is defined; otherwise zero/carry are tied low.
module data_unit
   import data_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    operation,
   input  logic          incpc,
   input  logic          clpc,
   input  logic          writeir,
   input  logic          writereg,
   input  logic          inmediate,
   input  logic [IW-1:0] instr_in,
   output logic [DW-1:0] pc_out,
   output logic [4:0]    opcode,
   input  logic [2:0]    dbg_sel,
   output logic [DW-1:0] dbg_data,
   output logic          zero,
   output logic          carry
);

   logic [DW-1:0] pc_q, pc_d;
   ir_t           ir_q, ir_d;
   logic [DW-1:0] regs_q [NREG];

   logic [DW-1:0] alu_a, alu_b, alu_res;
   logic          alu_cout;

   assign alu_a = regs_q[ir_q.ra];
   assign alu_b = inmediate ? ir_imm(ir_q) : regs_q[ir_q.rb];

   alu u_alu (
      .a         (alu_a),
      .b         (alu_b),
      .operation (operation),
      .result    (alu_res),
      .cout      (alu_cout)
   );

   always_comb begin
      pc_d = pc_q;
      if (clpc)       pc_d = '0;
      else if (incpc) pc_d = pc_q + 8'd1;
   end

   always_comb begin
      ir_d = ir_q;
      if (writeir) ir_d = ir_t'(instr_in);
   end

   // Operands come from pre-edge state, so rd==ra/rb and writeir+writereg
   // naturally use old values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
         ir_q <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         if (writereg) regs_q[ir_q.rd] <= alu_res;
      end
   end

   assign pc_out   = pc_q;
   assign opcode   = ir_q.opcode;
   assign dbg_data = regs_q[dbg_sel];

`ifdef YASAC_FLAGS_EN
   logic zero_q, carry_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (writereg) begin
         zero_q  <= (alu_res == '0);
         carry_q <= alu_cout;
      end
   end

   assign zero  = zero_q;
   assign carry = carry_q;
`else
   logic unused_cout;
   assign unused_cout = alu_cout;
   assign zero  = 1'b0;
   assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_data_unit.sv
// Self-checking bench for data_unit: an arithmetic reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_data_unit;
   import data_unit_pkg::*;

`ifdef YASAC_FLAGS_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  operation = 2'd0;
   logic        incpc = 1'b0, clpc = 1'b0, writeir = 1'b0, writereg = 1'b0, inmediate = 1'b0;
   logic [15:0] instr_in = 16'h0;
   logic [7:0]  pc_out;
   logic [4:0]  opcode;
   logic [2:0]  dbg_sel = 3'd0;
   logic [7:0]  dbg_data;
   logic        zero, carry;

   int checks = 0;
   int failures = 0;

   data_unit dut (
      .clk(clk), .reset(reset), .operation(operation), .incpc(incpc), .clpc(clpc),
      .writeir(writeir), .writereg(writereg), .inmediate(inmediate), .instr_in(instr_in),
      .pc_out(pc_out), .opcode(opcode), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
      .zero(zero), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on an array of register values
   int          m_reg [8];
   int          m_pc = 0;
   logic [15:0] m_ir = 16'h0;
   int          m_z = 0, m_c = 0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin : model
      int a, b, r, c;
      a = m_reg[m_ir[7:5]];
      b = inmediate ? int'(m_ir[7:0]) : m_reg[m_ir[4:2]];
      case (operation)
         2'd0:    begin r = a + b; c = (r > 255) ? 1 : 0; end
         2'd1:    begin r = a - b; c = (a < b) ? 1 : 0; end
         2'd2:    begin r = b; c = 0; end
         default: begin r = a; c = 0; end
      endcase
      r = r & 255;
      if (reset) begin
         m_valid <= 1'b1;
         m_pc <= 0; m_ir <= 16'h0; m_z <= 0; m_c <= 0;
         for (int i = 0; i < 8; i++) m_reg[i] <= 0;
      end else begin
         m_pc <= clpc ? 0 : (incpc ? (m_pc + 1) % 256 : m_pc);
         if (writeir) m_ir <= instr_in;
         if (writereg) begin
            m_reg[m_ir[10:8]] <= r;
            if (FL == 1) begin m_z <= (r == 0) ? 1 : 0; m_c <= c; end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cmp_pc", pc_out, m_pc);
         chk("cmp_opcode", opcode, int'(m_ir[15:11]));
         chk("cmp_dbg", dbg_data, m_reg[dbg_sel]);
         chk("cmp_zero", zero, m_z);
         chk("cmp_carry", carry, m_c);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      writeir = 0; writereg = 0; incpc = 0; clpc = 0; reset = 0;
   endtask

   task automatic load_ir(input logic [15:0] w);
      instr_in = w; writeir = 1; tick();
   endtask

   task automatic exec(input logic [1:0] op, input logic inm);
      operation = op; inmediate = inm; writereg = 1; tick();
   endtask

   task automatic ldi(input logic [2:0] r, input logic [7:0] v);
      load_ir({LDI, r, v});
      exec(ALU_TRB, 1'b1);
   endtask

   task automatic peek(input logic [2:0] sel, input int exp, input string name);
      dbg_sel = sel; #1;
      chk(name, dbg_data, exp);
   endtask

   initial begin
      reset = 1; repeat (2) @(posedge clk); #1; reset = 0;

      // preload every register, move the PC, then reset
      for (int i = 0; i < 8; i++) ldi(3'(i), 8'(8'h11 * (i + 1)));
      repeat (3) begin incpc = 1; tick(); end
      peek(3'd5, 8'h66, "preload_r5");
      chk("preload_pc", pc_out, 3);
      reset = 1; tick();
      chk("rst_pc", pc_out, 0);
      chk("rst_opcode", opcode, 0);
      for (int i = 0; i < 8; i++) peek(3'(i), 0, "rst_reg");
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);

      // LDI r3,#A5
      load_ir({LDI, 3'd3, 8'hA5});
      chk("ldi_opcode", opcode, int'(LDI));
      exec(ALU_TRB, 1'b1);
      peek(3'd3, 8'hA5, "ldi_r3");

      // ADD r1,r1,r2 with overflow
      ldi(3'd1, 8'hF0); ldi(3'd2, 8'h20);
      load_ir({ADD, 3'd1, 3'd1, 3'd2, 2'b00});
      exec(ALU_ADD, 1'b0);
      peek(3'd1, 8'h10, "add_r1");
      chk("add_carry", carry, FL);
      chk("add_zero", zero, 0);

      // SUB r5,r4,r4 -> zero
      ldi(3'd4, 8'h05);
      load_ir({SUB, 3'd5, 3'd4, 3'd4, 2'b00});
      exec(ALU_SUB, 1'b0);
      peek(3'd5, 8'h00, "sub_r5");
      chk("sub_zero", zero, FL);
      chk("sub_carry", carry, 0);

      // SUB r6,r1,r2 with borrow: 0x10-0x20
      load_ir({SUB, 3'd6, 3'd1, 3'd2, 2'b00});
      exec(ALU_SUB, 1'b0);
      peek(3'd6, 8'hF0, "subb_r6");
      chk("subb_carry", carry, FL);

      // MOV r0,r1
      load_ir({MOV, 3'd0, 3'd1, 3'd0, 2'b00});
      exec(ALU_TRA, 1'b0);
      peek(3'd0, 8'h10, "mov_r0");

      // writeir + writereg together: write uses old IR
      ldi(3'd7, 8'h11);
      instr_in = {MOV, 3'd7, 3'd0, 3'd0, 2'b00}; writeir = 1;
      operation = ALU_TRB; inmediate = 1; writereg = 1; tick();
      peek(3'd7, 8'h11, "irw_r7");
      chk("irw_opcode", opcode, int'(MOV));

      // PC wrap and clpc priority
      clpc = 1; tick();
      chk("pc_clr", pc_out, 0);
      repeat (255) begin incpc = 1; tick(); end
      chk("pc_255", pc_out, 255);
      incpc = 1; tick();
      chk("pc_wrap", pc_out, 0);
      repeat (7) begin incpc = 1; tick(); end
      chk("pc_7", pc_out, 7);
      clpc = 1; incpc = 1; tick();
      chk("pc_clpc_prio", pc_out, 0);

      // reset in the same edge as writereg/writeir/incpc
      reset = 1; tick();
      load_ir({LDI, 3'd6, 8'h77});
      instr_in = {ADD, 11'h0}; writeir = 1; incpc = 1;
      operation = ALU_TRB; inmediate = 1; writereg = 1; reset = 1; tick();
      peek(3'd6, 0, "rstw_r6");
      chk("rstw_pc", pc_out, 0);
      chk("rstw_opcode", opcode, 0);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
